// File: rtl/magnetron_ctrl.sv
// Cook-cycle controller driving the magnetron SR latch; optional DONE hold via DONE_HOLD_EN.
// Latency: input sampled at edge k -> registered pulse/state in cycle k+1.
// Backpressure: none; pulses are fire-and-forget, keys outside the current state are ignored.
module magnetron_ctrl #(
  parameter int TICK_DIV = 100,
  parameter int TIME_W   = 12,
  parameter int BEEP_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              door_closed,
  input  logic              load,
  input  logic [TIME_W-1:0] load_time,
  output logic              mag_set,
  output logic              mag_reset,
  output logic [TIME_W-1:0] remaining,
  output logic              busy,
  output logic              done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  if (TICK_DIV < 2 || BEEP_CYC < 1) begin : g_param_check
    $error("magnetron_ctrl: TICK_DIV must be >= 2 and BEEP_CYC >= 1");
  end

  typedef enum logic [1:0] {IDLE, COOK, PAUSE, DONE} state_t;

  state_t            state_q, state_d;
  logic [TIME_W-1:0] remaining_q, remaining_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              mag_set_q, mag_set_d;
  logic              mag_reset_q, mag_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick;

`ifdef DONE_HOLD_EN
  localparam int HW = (BEEP_CYC > 1) ? $clog2(BEEP_CYC) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(BEEP_CYC - 1);
  logic [HW-1:0] hold_q, hold_d;
`endif

  assign tick = (presc_q == PRESC_MAX);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    presc_d     = presc_q;
    mag_set_d   = 1'b0;
    mag_reset_d = 1'b0;
`ifdef DONE_HOLD_EN
    hold_d      = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (stop) begin
          remaining_d = '0;
        end else if (start && door_closed && remaining_q != '0) begin
          state_d   = COOK;
          mag_set_d = 1'b1;
          presc_d   = '0;
        end else if (load) begin
          remaining_d = load_time;
        end
      end
      COOK: begin
        if (tick && remaining_q == TIME_W'(1)) begin
          state_d     = DONE;
          mag_reset_d = 1'b1;
          remaining_d = '0;
          presc_d     = '0;
`ifdef DONE_HOLD_EN
          hold_d      = '0;
`endif
        end else begin
          if (tick && remaining_q != '0) remaining_d = remaining_q - TIME_W'(1);
          // Pausing freezes the sub-second phase so the resumed second is not lost.
          if (!door_closed || stop) begin
            state_d     = PAUSE;
            mag_reset_d = 1'b1;
            presc_d     = tick ? '0 : presc_q;
          end else begin
            presc_d     = tick ? '0 : presc_q + PW'(1);
          end
        end
      end
      PAUSE: begin
        if (stop) begin
          state_d     = IDLE;
          remaining_d = '0;
        end else if (start && door_closed && remaining_q != '0) begin
          state_d   = COOK;
          mag_set_d = 1'b1;
        end else if (load) begin
          remaining_d = load_time;
        end
      end
      DONE: begin
`ifdef DONE_HOLD_EN
        if (stop || hold_q == HOLD_MAX) state_d = IDLE;
        else                            hold_d  = hold_q + HW'(1);
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == COOK);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      presc_q     <= '0;
      mag_set_q   <= 1'b0;
      mag_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DONE_HOLD_EN
      hold_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      presc_q     <= presc_d;
      mag_set_q   <= mag_set_d;
      mag_reset_q <= mag_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef DONE_HOLD_EN
      hold_q      <= hold_d;
`endif
    end
  end

  assign mag_set   = mag_set_q;
  assign mag_reset = mag_reset_q;
  assign remaining = remaining_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_magnetron_ctrl.sv
// Bench for magnetron_ctrl: cycle-accurate reference model plus directed literal checks.
module tb_magnetron_ctrl;
  localparam int TD = 4;
  localparam int TW = 12;
  localparam int BC = 8;
`ifdef DONE_HOLD_EN
  localparam int DONE_LEN = BC;
  localparam bit HOLD     = 1'b1;
`else
  localparam int DONE_LEN = 1;
  localparam bit HOLD     = 1'b0;
`endif
  localparam int S_IDLE = 0, S_COOK = 1, S_PAUSE = 2, S_DONE = 3;

  logic          clk = 1'b0;
  logic          rst, start, stop, door_closed, load;
  logic [TW-1:0] load_time;
  logic          mag_set, mag_reset, busy, done;
  logic [TW-1:0] remaining;

  int vectors = 0;
  int miscompares = 0;

  magnetron_ctrl #(.TICK_DIV(TD), .TIME_W(TW), .BEEP_CYC(BC)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .door_closed(door_closed),
    .load(load), .load_time(load_time), .mag_set(mag_set), .mag_reset(mag_reset),
    .remaining(remaining), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Model: remaining = loaded seconds minus whole seconds of cook time elapsed.
  int m_st = S_IDLE;
  int m_base = 0;
  int m_cooked = 0;
  int m_dcnt = 0;
  int m_r;
  bit m_second_ends;
  bit e_set = 1'b0, e_rst = 1'b0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_st = S_IDLE; m_base = 0; m_cooked = 0; m_dcnt = 0;
      e_set = 1'b0; e_rst = 1'b1; m_valid = 1'b1;
    end else begin
      m_r = m_base - m_cooked / TD;
      e_set = 1'b0; e_rst = 1'b0;
      case (m_st)
        S_IDLE: begin
          if (stop) begin m_base = 0; m_cooked = 0; end
          else if (start && door_closed && m_r != 0) begin
            m_st = S_COOK; e_set = 1'b1; m_base = m_r; m_cooked = 0;
          end else if (load) begin m_base = int'(load_time); m_cooked = 0; end
        end
        S_COOK: begin
          m_second_ends = (m_cooked % TD) == TD - 1;
          if (m_second_ends && m_r == 1) begin
            m_st = S_DONE; e_rst = 1'b1; m_base = 0; m_cooked = 0; m_dcnt = 0;
          end else if (!door_closed || stop) begin
            m_st = S_PAUSE; e_rst = 1'b1;
            if (m_second_ends) m_cooked = m_cooked + 1;
          end else begin
            m_cooked = m_cooked + 1;
          end
        end
        S_PAUSE: begin
          if (stop) begin m_st = S_IDLE; m_base = 0; m_cooked = 0; end
          else if (start && door_closed && m_r != 0) begin m_st = S_COOK; e_set = 1'b1; end
          else if (load) begin m_base = int'(load_time); m_cooked = m_cooked % TD; end
        end
        default: begin
          m_dcnt = m_dcnt + 1;
          if (m_dcnt >= DONE_LEN || (HOLD && stop)) m_st = S_IDLE;
        end
      endcase
    end
  end

  task automatic cmp(input string nm, input int act, input int exp);
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, want %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      vectors++;
      cmp("mdl_mag_set", int'(mag_set), int'(e_set));
      cmp("mdl_mag_reset", int'(mag_reset), int'(e_rst));
      cmp("mdl_remaining", int'(remaining), m_base - m_cooked / TD);
      cmp("mdl_busy", int'(busy), int'(m_st == S_COOK));
      cmp("mdl_done", int'(done), int'(m_st == S_DONE));
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    cmp(nm, act, exp);
  endtask

  task automatic pulse(input bit s, input bit sp, input bit ld, input int lt);
    start = s; stop = sp; load = ld; load_time = TW'(lt);
    @(negedge clk);
    start = 1'b0; stop = 1'b0; load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int n;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0; load_time = '0; door_closed = 1'b1;
    // Reset and release
    idle(2);
    chk("rst_mag_reset", int'(mag_reset), 1);
    chk("rst_remaining", int'(remaining), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    idle(1);
    chk("rel_mag_reset", int'(mag_reset), 0);

    // Full 3-second cook
    pulse(0, 0, 1, 3);
    chk("ld3_rem", int'(remaining), 3);
    pulse(1, 0, 0, 0);
    chk("cook_set", int'(mag_set), 1);
    chk("cook_busy", int'(busy), 1);
    idle(1);
    chk("set_one_cyc", int'(mag_set), 0);
    idle(2);
    chk("rem3_hold", int'(remaining), 3);
    idle(1);
    chk("rem_2", int'(remaining), 2);
    idle(4);
    chk("rem_1", int'(remaining), 1);
    idle(4);
    chk("fin_done", int'(done), 1);
    chk("fin_mag_reset", int'(mag_reset), 1);
    chk("fin_rem", int'(remaining), 0);
    n = 0;
    while (done && n < 20) begin n++; @(negedge clk); end
    chk("done_len", n, DONE_LEN);

    // Door opened mid-second, then resumed
    pulse(0, 0, 1, 5);
    pulse(1, 0, 0, 0);
    idle(5);
    chk("pre_open_rem", int'(remaining), 4);
    door_closed = 1'b0;
    pulse(0, 0, 0, 0);
    chk("open_reset", int'(mag_reset), 1);
    chk("open_busy", int'(busy), 0);
    chk("open_rem", int'(remaining), 4);
    pulse(1, 0, 0, 0);
    chk("open_start_noset", int'(mag_set), 0);
    door_closed = 1'b1;
    pulse(1, 0, 0, 0);
    chk("resume_set", int'(mag_set), 1);
    idle(2);
    chk("resume_rem4", int'(remaining), 4);
    idle(1);
    chk("resume_rem3", int'(remaining), 3);
    pulse(0, 1, 0, 0);
    pulse(0, 1, 0, 0);

    // Stop pauses, second stop clears
    pulse(0, 0, 1, 7);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    chk("stop_reset", int'(mag_reset), 1);
    chk("stop_rem", int'(remaining), 7);
    pulse(0, 1, 0, 0);
    chk("stop2_rem", int'(remaining), 0);
    pulse(1, 0, 0, 0);
    chk("idle0_noset", int'(mag_set), 0);
    chk("idle0_busy", int'(busy), 0);

    // Door opens on the final tick
    pulse(0, 0, 1, 1);
    pulse(1, 0, 0, 0);
    idle(3);
    door_closed = 1'b0;
    pulse(0, 0, 0, 0);
    chk("lastopen_done", int'(done), 1);
    chk("lastopen_reset", int'(mag_reset), 1);
    chk("lastopen_rem", int'(remaining), 0);
    n = 0;
    repeat (12) begin @(negedge clk); if (mag_reset) n++; end
    chk("lastopen_extra_rst", n, 0);
    door_closed = 1'b1;

    // Stop beats start in PAUSE; loaded zero blocks start
    pulse(0, 0, 1, 4);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    pulse(1, 1, 0, 0);
    chk("stopwin_set", int'(mag_set), 0);
    chk("stopwin_rem", int'(remaining), 0);
    pulse(0, 0, 1, 4);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    pulse(0, 0, 1, 0);
    chk("pld0_rem", int'(remaining), 0);
    pulse(1, 0, 0, 0);
    chk("pld0_noset", int'(mag_set), 0);
    pulse(0, 1, 0, 0);

`ifdef DONE_HOLD_EN
    pulse(0, 0, 1, 1);
    pulse(1, 0, 0, 0);
    idle(4);
    chk("hold_done", int'(done), 1);
    pulse(0, 1, 0, 0);
    chk("hold_stop", int'(done), 0);
`endif

    // Reset mid-cook
    pulse(0, 0, 1, 9);
    pulse(1, 0, 0, 0);
    idle(2);
    rst = 1'b1;
    idle(1);
    chk("midrst_reset", int'(mag_reset), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_rem", int'(remaining), 0);
    rst = 1'b0;
    idle(2);
    chk("midrst_release", int'(mag_reset), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
